// File: rtl/ram_dump_reader.sv
// ---------------------------------------------------------------------------
// ram_dump_reader
//
// Streams a block of bytes out of a small synchronous RAM into a UART
// transmitter. A dump is started with a start pulse while idle; the reader
// then walks the RAM from start_addr for length bytes. The address wraps
// modulo the RAM depth. Each byte goes out through a valid/ready handshake.
//
// Optional feature (macro RAM_DUMP_CLEAR_EN): after the last byte of a
// non-empty dump, the reader pulses ram_clear for one cycle. It then waits
// 65 cycles for the RAM's 64-cycle clear sequence, plus one cycle of margin,
// before signalling done. When the macro is undefined, ram_clear is
// constant 0.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   begin a dump (only honoured while idle)
//   start_addr  in   [ADDR_W-1:0] first RAM address to read
//   length      in   [ADDR_W:0]   byte count, clamped to the RAM depth
//   busy        out  high whenever the reader is not idle
//   done        out  one-cycle pulse at the end of a dump
//   ram_addr    out  [ADDR_W-1:0] RAM read address (holds outside reads)
//   ram_wr_en   out  RAM write enable, always 0
//   ram_clear   out  RAM clear request (see optional feature above)
//   ram_rdata   in   [DATA_W-1:0] registered RAM read data
//   tx_data     out  [DATA_W-1:0] byte to the transmitter
//   tx_valid    out  tx_data is valid
//   tx_ready    in   transmitter accepts tx_data when tx_valid is high
// ---------------------------------------------------------------------------
module ram_dump_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr_en,
  output logic              ram_clear,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int            DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

`ifdef RAM_DUMP_CLEAR_EN
  // The RAM needs 64 cycles to clear itself. One extra cycle of margin
  // gives 65 cycles in CLR_WAIT, with the counter running from 0 to 64.
  localparam logic [6:0] CLR_WAIT_LAST = 7'd64;
`endif

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    CLEAR,
    CLR_WAIT,
    DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr_next;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W:0]     remaining_next;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [ADDR_W-1:0]   ram_addr_next;
  logic [DATA_W-1:0]   tx_data_q;
  logic [DATA_W-1:0]   tx_data_next;
  logic [ADDR_W:0]     length_clamped;

`ifdef RAM_DUMP_CLEAR_EN
  logic [6:0]          wait_cnt;
  logic [6:0]          wait_next;
`endif

  // Requests longer than the RAM are limited to a single full pass.
  assign length_clamped = (length > MAX_LEN) ? MAX_LEN : length;

  // State and datapath registers. Everything returns to zero or IDLE on
  // reset, so a reset in the middle of a dump abandons it immediately.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      ram_addr_q <= '0;
      tx_data_q  <= '0;
`ifdef RAM_DUMP_CLEAR_EN
      wait_cnt   <= '0;
`endif
    end else begin
      state      <= state_next;
      addr       <= addr_next;
      remaining  <= remaining_next;
      ram_addr_q <= ram_addr_next;
      tx_data_q  <= tx_data_next;
`ifdef RAM_DUMP_CLEAR_EN
      wait_cnt   <= wait_next;
`endif
    end
  end

  // Next-state and datapath updates.
  //
  // ram_addr is loaded only on the transition into READ. As a result, it
  // presents the read address during READ and keeps that value in every
  // other state, including after the final address increment.
  always_comb begin
    state_next     = state;
    addr_next      = addr;
    remaining_next = remaining;
    ram_addr_next  = ram_addr_q;
    tx_data_next   = tx_data_q;
`ifdef RAM_DUMP_CLEAR_EN
    wait_next      = wait_cnt;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_next = DONE;
          end else begin
            addr_next      = start_addr;
            remaining_next = length_clamped;
            ram_addr_next  = start_addr;
            state_next     = READ;
          end
        end
      end

      READ: begin
        state_next = CAPTURE;
      end

      CAPTURE: begin
        tx_data_next = ram_rdata;
        state_next   = SEND;
      end

      SEND: begin
        if (tx_ready) begin
          remaining_next = remaining - 1'b1;
          addr_next      = addr + 1'b1;
          if (remaining == (ADDR_W + 1)'(1)) begin
`ifdef RAM_DUMP_CLEAR_EN
            state_next = CLEAR;
`else
            state_next = DONE;
`endif
          end else begin
            ram_addr_next = addr + 1'b1;
            state_next    = READ;
          end
        end
      end

      CLEAR: begin
`ifdef RAM_DUMP_CLEAR_EN
        wait_next  = '0;
        state_next = CLR_WAIT;
`else
        state_next = DONE;
`endif
      end

      CLR_WAIT: begin
`ifdef RAM_DUMP_CLEAR_EN
        if (wait_cnt == CLR_WAIT_LAST) begin
          state_next = DONE;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
`else
        state_next = DONE;
`endif
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign tx_valid  = (state == SEND);
  assign tx_data   = tx_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr_en = 1'b0;

`ifdef RAM_DUMP_CLEAR_EN
  assign ram_clear = (state == CLEAR);
`else
  assign ram_clear = 1'b0;
`endif

endmodule

// File: doc/ram_dump_reader.md
RAM_DUMP_READER -- requirements
Module: ram_dump_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM address width (64 locations).
REQ-002 SHALL have parameter DATA_W, default 8, RAM/byte data width.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin dump, sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_W  first RAM address to read.
REQ-007 SHALL have port length  input  ADDR_W+1  byte count, 0..64.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of dump.
REQ-010 SHALL have port ram_addr  output  ADDR_W  address to the RAM.
REQ-011 SHALL have port ram_wr_en  output  1  RAM write enable; tied 0 (reads only).
REQ-012 SHALL have port ram_clear  output  1  RAM clear request (see Configuration).
REQ-013 SHALL have port ram_rdata  input  DATA_W  RAM registered read data, valid one cycle after address presented.
REQ-014 SHALL have port tx_data  output  DATA_W  byte to UART transmitter.
REQ-015 SHALL have port tx_valid  output  1  tx_data valid.
REQ-016 SHALL have port tx_ready  input  1  transmitter accepts byte when tx_valid and tx_ready both high.

Function
REQ-017 SHALL implement FSM states IDLE, READ, CAPTURE, SEND, CLEAR, CLR_WAIT, DONE.
REQ-018 IDLE: start=1 and length!=0 -> load addr=start_addr, remaining=length (values above 64 clamped to 64), go READ; start=1 and length=0 -> DONE; otherwise stay.
REQ-019 READ: drive ram_addr=addr, ram_wr_en=0; next state CAPTURE.
REQ-020 CAPTURE: register ram_rdata into tx_data; next state SEND.
REQ-021 SEND: tx_valid=1; on tx_valid&tx_ready, decrement remaining, increment addr modulo 64 (63 wraps to 0); if remaining was 1 go CLEAR (macro set) or DONE, else READ.
REQ-022 Latency: start sampled in cycle N -> tx_valid first high in cycle N+3; with tx_ready held 1, one byte per 3 cycles.
REQ-023 tx_data SHALL hold stable while tx_valid=1 and tx_ready=0; tx_valid SHALL not drop before the handshake completes.
REQ-024 start while busy=1 SHALL be ignored; inputs start_addr/length SHALL be sampled only at the IDLE exit.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE.
REQ-026 ram_addr SHALL hold last driven value outside READ; ram_wr_en SHALL be 0 in all states.

Reset
REQ-027 On reset SHALL go IDLE with busy=0, done=0, tx_valid=0, tx_data=0, ram_addr=0, ram_clear=0, counters=0.
REQ-028 Reset mid-dump SHALL abort immediately; no further tx_valid, done or ram_clear until a new start.

Configuration
REQ-029 Macro RAM_DUMP_CLEAR_EN SHALL compile in clear-after-dump.
REQ-030 With RAM_DUMP_CLEAR_EN defined: after final handshake enter CLEAR, pulse ram_clear for one cycle, then CLR_WAIT for 65 cycles (RAM 64-cycle clear plus margin), then DONE.
REQ-031 Without RAM_DUMP_CLEAR_EN: ram_clear SHALL be constant 0, CLEAR/CLR_WAIT unreachable, final handshake goes directly to DONE.
REQ-032 length=0 SHALL never trigger a clear in either configuration.

Verification
REQ-033 RAM preloaded addr k = k; start_addr=5, length=3, tx_ready=1 -> tx bytes 0x05,0x06,0x07, tx_valid first at N+3, done pulse once, busy low after.
REQ-034 start_addr=62, length=4 -> bytes 0x3E,0x3F,0x00,0x01 (wrap-around).
REQ-035 tx_ready=0 for 10 cycles during first byte -> tx_valid and tx_data=0x05 held constant, no address advance.
REQ-036 length=0 -> done pulses at N+1, no tx_valid, ram_clear=0; length=100 -> exactly 64 bytes.
REQ-037 Reset asserted after 2nd byte of length=8 dump -> all outputs at reset values next cycle, no done, no further bytes.
REQ-038 RAM_DUMP_CLEAR_EN defined, length=2 -> single-cycle ram_clear after 2nd handshake, done exactly 66 cycles later, readback of all 64 RAM locations = 0x00.
